// File: rtl/video_pattern_gen_if.sv
// Pixel output bus of the video pattern generator: RGB data, data-valid and syncs.
// The frame_cnt member exists only when VPG_FRAME_CNT_EN is defined.
interface video_pattern_gen_if;
  logic [7:0]  tx_red;
  logic [7:0]  tx_green;
  logic [7:0]  tx_blue;
  logic        tx_dv;
  logic        tx_hs;
  logic        tx_vs;
`ifdef VPG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs
`ifdef VPG_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs
`ifdef VPG_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing plus test-pattern generator (bars, gradient, checker, solid) with registered outputs.
// Optional macro VPG_FRAME_CNT_EN adds a 16-bit frame counter and a scrolling gradient.
module video_pattern_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [23:0] solid_rgb,
  video_pattern_gen_if.master tx
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are kept wide enough for the gradient (bits 7:0) and checker (bit 4) taps.
  localparam int HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW      = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic [BW-1:0] bar_px_reg;
  logic [2:0]    bar_idx_reg;
  logic [1:0]    pat_reg;
  logic [23:0]   solid_reg;
  logic [7:0]    red_reg;
  logic [7:0]    green_reg;
  logic [7:0]    blue_reg;
  logic          dv_reg;
  logic          hs_reg;
  logic          vs_reg;

  logic          h_last;
  logic          v_last;
  logic          frame_start;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic [1:0]    pat_eff;
  logic [23:0]   solid_eff;
  logic [7:0]    grad;
  logic [23:0]   rgb_next;

  assign h_last      = (h_cnt_reg == H_LAST);
  assign v_last      = (v_cnt_reg == V_LAST);
  assign frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign active      = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_on       = (h_cnt_reg >= H_HS_BEG) && (h_cnt_reg < H_HS_END);
  assign vs_on       = (v_cnt_reg >= V_VS_BEG) && (v_cnt_reg < V_VS_END);

  // The first pixel of a frame already uses the selection being sampled at that pixel.
  assign pat_eff     = frame_start ? pat_sel   : pat_reg;
  assign solid_eff   = frame_start ? solid_rgb : solid_reg;

`ifdef VPG_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (en && h_last && v_last) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign tx.frame_cnt = frame_cnt_reg;
  assign grad         = h_cnt_reg[7:0] + frame_cnt_reg[7:0];
`else
  assign grad         = h_cnt_reg[7:0];
`endif

  always_comb begin
    rgb_next = 24'h000000;
    case (pat_eff)
      2'd0: begin
        case (bar_idx_reg)
          3'd0:    rgb_next = 24'hFFFFFF;
          3'd1:    rgb_next = 24'hFFFF00;
          3'd2:    rgb_next = 24'h00FFFF;
          3'd3:    rgb_next = 24'h00FF00;
          3'd4:    rgb_next = 24'hFF00FF;
          3'd5:    rgb_next = 24'hFF0000;
          3'd6:    rgb_next = 24'h0000FF;
          default: rgb_next = 24'h000000;
        endcase
      end
      2'd1:    rgb_next = {grad, grad, grad};
      2'd2:    rgb_next = (h_cnt_reg[4] ^ v_cnt_reg[4]) ? 24'hFFFFFF : 24'h000000;
      default: rgb_next = solid_eff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
      pat_reg     <= '0;
      solid_reg   <= '0;
      red_reg     <= '0;
      green_reg   <= '0;
      blue_reg    <= '0;
      dv_reg      <= 1'b0;
      hs_reg      <= ~HS_POL;
      vs_reg      <= ~VS_POL;
    end else if (!en) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
      pat_reg     <= pat_sel;
      solid_reg   <= solid_rgb;
      red_reg     <= '0;
      green_reg   <= '0;
      blue_reg    <= '0;
      dv_reg      <= 1'b0;
      hs_reg      <= ~HS_POL;
      vs_reg      <= ~VS_POL;
    end else begin
      if (frame_start) begin
        pat_reg   <= pat_sel;
        solid_reg <= solid_rgb;
      end

      h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
      if (h_last) begin
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
      end

      // Bar index advances every BAR_W active pixels, avoiding a divider on h_cnt.
      if (h_last) begin
        bar_px_reg  <= '0;
        bar_idx_reg <= '0;
      end else if (h_cnt_reg < H_ACT) begin
        if (bar_px_reg == BAR_LAST) begin
          bar_px_reg  <= '0;
          bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
          bar_px_reg  <= bar_px_reg + 1'b1;
        end
      end

      dv_reg    <= active;
      red_reg   <= active ? rgb_next[23:16] : 8'h00;
      green_reg <= active ? rgb_next[15:8]  : 8'h00;
      blue_reg  <= active ? rgb_next[7:0]   : 8'h00;
      hs_reg    <= hs_on ? HS_POL : ~HS_POL;
      vs_reg    <= vs_on ? VS_POL : ~VS_POL;
    end
  end

  assign tx.tx_red   = red_reg;
  assign tx.tx_green = green_reg;
  assign tx.tx_blue  = blue_reg;
  assign tx.tx_dv    = dv_reg;
  assign tx.tx_hs    = hs_reg;
  assign tx.tx_vs    = vs_reg;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a tiny 14x7 raster: a frame-position model
// predicts each clock's outputs, a monitor on the falling edge compares them.
module tb_video_pattern_gen;
  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pat_sel;
  logic [23:0] solid_rgb;

  always #5 clk = ~clk;

  video_pattern_gen_if tx_bus ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pat_sel(pat_sel),
    .solid_rgb(solid_rgb),
    .tx(tx_bus)
  );

  typedef struct packed {
    logic        dv;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: a single linear position within the frame.
  int          pos = 0;
  logic [1:0]  m_pat;
  logic [23:0] m_solid;
  logic [15:0] m_frame;
  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic model_step(output obs_t e);
    int x;
    int y;
    logic [7:0] g;
    e = '0;
    if (rst) begin
      pos = 0; m_pat = 2'd0; m_solid = 24'h0; m_frame = 16'h0;
    end else if (!en) begin
      pos = 0; m_pat = pat_sel; m_solid = solid_rgb;
    end else begin
      x = pos % HT;
      y = pos / HT;
      if (pos == 0) begin
        m_pat   = pat_sel;
        m_solid = solid_rgb;
      end
      e.dv = (x < HA) && (y < VA);
      e.hs = (x >= HA + HF) && (x < HA + HF + HSY);
      e.vs = (y >= VA + VF) && (y < VA + VF + VSY);
      if (e.dv) begin
        case (m_pat)
          2'd0: e.rgb = bar_col[x / (HA / 8)];
          2'd1: begin
            g = 8'(x);
`ifdef VPG_FRAME_CNT_EN
            g = g + m_frame[7:0];
`endif
            e.rgb = {g, g, g};
          end
          2'd2: e.rgb = (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
          default: e.rgb = m_solid;
        endcase
      end
      pos = (pos + 1) % FT;
      if (pos == 0) m_frame = m_frame + 16'd1;
    end
`ifdef VPG_FRAME_CNT_EN
    e.fc = m_frame;
`else
    e.fc = 16'h0;
`endif
  endtask

  task automatic step();
    obs_t e;
    model_step(e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  obs_t mon_exp;
  obs_t mon_act;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      mon_exp       = exp_q.pop_front();
      mon_act.dv    = tx_bus.tx_dv;
      mon_act.hs    = tx_bus.tx_hs;
      mon_act.vs    = tx_bus.tx_vs;
      mon_act.rgb   = {tx_bus.tx_red, tx_bus.tx_green, tx_bus.tx_blue};
`ifdef VPG_FRAME_CNT_EN
      mon_act.fc    = tx_bus.frame_cnt;
`else
      mon_act.fc    = 16'h0;
`endif
      n_tests = n_tests + 1;
      if (mon_act !== mon_exp) begin
        n_fail = n_fail + 1;
        $display("FAIL pixel cyc=%0d dv/hs/vs act=%b%b%b exp=%b%b%b rgb act=%06h exp=%06h fc act=%0d exp=%0d",
                 cyc, mon_act.dv, mon_act.hs, mon_act.vs, mon_exp.dv, mon_exp.hs, mon_exp.vs,
                 mon_act.rgb, mon_exp.rgb, mon_act.fc, mon_exp.fc);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; pat_sel = 2'd0; solid_rgb = 24'h0;
    run(2);
    rst = 1'b0;
    run(3);
    $display("[TB] reset and idle: 5 cycles");

    en = 1'b1;
    pat_sel = 2'd0; run(2 * FT);
    $display("[TB] colour bars: %0d cycles", 2 * FT);
    pat_sel = 2'd1; run(FT);
    $display("[TB] gradient: %0d cycles", FT);
    pat_sel = 2'd2; run(FT);
    $display("[TB] checkerboard: %0d cycles", FT);
    pat_sel = 2'd3; solid_rgb = 24'($urandom); run(FT);
    $display("[TB] solid %06h: %0d cycles", solid_rgb, FT);

    en = 1'b0; run(1);
    en = 1'b1; pat_sel = 2'd3; solid_rgb = 24'h123456;
    run(40);
    pat_sel = 2'd2; solid_rgb = 24'hABCDEF;
    run(FT - 40 + FT);
    $display("[TB] mid-frame switch 3->2: %0d cycles", 2 * FT);

    en = 1'b0; run(1);
    en = 1'b1; pat_sel = 2'd0;
    run(2 * HT + 5);
    en = 1'b0; run(3);
    en = 1'b1; run(FT + 20);
    $display("[TB] enable drop at line 2 pixel 5 and restart");

    run(50);
    rst = 1'b1; run(1);
    rst = 1'b0; run(60);
    $display("[TB] reset pulse mid-frame");

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 29) == 0) pat_sel = 2'($urandom_range(0, 3));
      solid_rgb = 24'($urandom);
      step();
    end
    rst = 1'b0;
    $display("[TB] randomized: 3000 cycles");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 1280 active pixels/line (multiple of 8); H_FP 110 h front porch; H_SYNC 40 h sync width; H_BP 220 h back porch.
REQ-002 Parameters: V_ACTIVE 720 active lines; V_FP 5 v front porch; V_SYNC 5 v sync width; V_BP 20 v back porch; HS_POL 1 hs active level; VS_POL 1 vs active level.
REQ-003 Ports: clk input 1 pixel clock; rst input 1 reset (one clock; reset is synchronous and active-high).
REQ-004 Ports: en input 1 run enable; pat_sel input 2 pattern select; solid_rgb input 24 solid colour {R,G,B}.
REQ-005 Ports: tx_red, tx_green, tx_blue output 8 each pixel data; tx_dv, tx_hs, tx_vs output 1 each data-valid and syncs.

Function
REQ-006 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H_* params), wraps to 0; v_cnt increments on h wrap, counts 0..V_TOTAL-1, wraps to 0.
REQ-007 Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-008 hs active (HS_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; else !HS_POL.
REQ-009 vs active (VS_POL) for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, changing only with v_cnt (aligned to h wrap); else !VS_POL.
REQ-010 All outputs registered; latency exactly 1 clk from counter state to tx_* outputs.
REQ-011 tx_red/green/blue SHALL be 0 whenever tx_dv is 0.
REQ-012 pat_sel and solid_rgb sampled into internal registers only when h_cnt=0 and v_cnt=0 (frame start); mid-frame changes take effect next frame.
REQ-013 Pattern 0 colour bars: 8 bars of H_ACTIVE/8 pixels, order white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00); bar index from a bar-width counter, no divider.
REQ-014 Pattern 1 gradient: R=G=B=h_cnt[7:0].
REQ-015 Pattern 2 checkerboard: white when h_cnt[4]^v_cnt[4]=1, else black.
REQ-016 Pattern 3 solid: sampled solid_rgb.
REQ-017 en low: counters held at 0, pattern registers load continuously, outputs idle (dv 0, rgb 0, hs !HS_POL, vs !VS_POL).
REQ-018 en deasserted mid-frame: frame aborted, idle state next clk; en re-asserted: restarts at h_cnt=0, v_cnt=0, first pixel on tx one clk later.

Reset
REQ-019 rst high at a clk edge: h_cnt, v_cnt, bar counter 0; pattern register 0; tx_dv 0, rgb 0, tx_hs !HS_POL, tx_vs !VS_POL.
REQ-020 rst overrides en; reset mid-frame restarts timing at frame start after release.

Configuration
REQ-021 Macro VPG_FRAME_CNT_EN defined: adds output frame_cnt (16 bits), reset 0, incremented (wrapping at 16'hFFFF) registered aligned with tx_* when counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0); pattern 1 becomes R=G=B=h_cnt[7:0]+frame_cnt[7:0] (scrolling).
REQ-022 Macro undefined: no frame_cnt port and no frame counter logic; pattern 1 per REQ-014.

Verification
REQ-023 Params H 8/2/2/2, V 4/1/1/1, en=1 from reset: tx_dv high 8 of 14 clks per line, 4 active lines per 7-line frame, 98 clks/frame.
REQ-024 Same params: tx_hs high exactly clks 10..11 of each line (h_cnt offset +1 latency); tx_vs high for all 14 clks of line 5 each frame.
REQ-025 pat_sel=0 with H_ACTIVE=8: active pixels per line FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-026 pat_sel switched 3->2 mid-frame, solid_rgb=123456: remainder of frame 123456, next frame checkerboard; rgb 0 on every tx_dv=0 clk.
REQ-027 en dropped at h_cnt=5 on line 2 then raised 3 clks later: idle outputs next clk, restart at frame start; rst pulse mid-frame gives REQ-019 values next clk.
REQ-028 VPG_FRAME_CNT_EN defined: frame_cnt reads 0,1,2 over three frames; pattern 1 first pixel of frame 2 equals 020202.
